// File: rtl/leg_ctrl_pkg.sv
// Shared types for the LEG core control path: condition codes, NZCV bit
// positions and the Execute-stage control record.
package leg_ctrl_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // The opaque Ctrl field is parameter-sized, so it lives beside this record.
  typedef struct packed {
    logic       valid;
    cond_e      cond;
    logic [1:0] flag_write;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       pc_write;
  } stage_ctrl_t;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-field evaluator: decides whether an instruction with the
// given condition executes under the current NZCV flags.
module cond_eval
  import leg_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    // NOTE: pass gets a default before the case so every path assigns it and no latch is inferred.
    pass = 1'b0;
    case (cond_e'(cond))
      EQ:      pass = z;
      NE:      pass = ~z;
      CS:      pass = c;
      CC:      pass = ~c;
      MI:      pass = n;
      PL:      pass = ~n;
      VS:      pass = v;
      VC:      pass = ~v;
      HI:      pass = c & ~z;
      LS:      pass = ~c | z;
      GE:      pass = (n == v);
      LT:      pass = (n != v);
      GT:      pass = ~z & (n == v);
      LE:      pass = z | (n != v);
      AL:      pass = 1'b1;
      NV:      pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline from Decode through NSTAGES post-decode stages,
// with condition gating in Execute, NZCV ownership and per-stage stall/flush.
module ctrl_pipe
  import leg_ctrl_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int CTRLW   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ValidD,
  input  logic [3:0]                 CondD,
  input  logic [1:0]                 FlagWriteD,
  input  logic                       BranchD,
  input  logic                       RegWriteD,
  input  logic                       MemWriteD,
  input  logic                       PCWriteD,
  input  logic [CTRLW-1:0]           CtrlD,
  input  logic [3:0]                 ALUFlagsE,
  input  logic [NSTAGES-1:0]         Stall,
  input  logic [NSTAGES-1:0]         Flush,
  output logic                       CondExE,
  output logic                       BranchTakenE,
  output logic                       CarryInE,
  output logic [3:0]                 FlagsQ,
  output logic [NSTAGES-1:0]         ValidS,
  output logic [NSTAGES-1:0]         RegWriteS,
  output logic [NSTAGES-1:0]         MemWriteS,
  output logic [NSTAGES-1:0]         PCWriteS,
  output logic [NSTAGES*CTRLW-1:0]   CtrlS,
  output logic                       PCWrPendingF
);

  stage_ctrl_t      dec;
  stage_ctrl_t      ex_q;
  logic [CTRLW-1:0] ex_ctrl_q;
  logic [3:0]       flags_q;
  logic             cond_pass;

  // Stages 1..NSTAGES-1 keep only the already-gated enables.
  logic [NSTAGES-1:1] valid_q, rw_q, mw_q, pw_q;
  logic [CTRLW-1:0]   ctrl_q [1:NSTAGES-1];

  logic [NSTAGES-1:1] src_valid, src_rw, src_mw, src_pw;
  logic [CTRLW-1:0]   src_ctrl [1:NSTAGES-1];

  assign dec = '{
    valid:      ValidD,
    cond:       cond_e'(CondD),
    flag_write: FlagWriteD,
    branch:     BranchD,
    reg_write:  RegWriteD,
    mem_write:  MemWriteD,
    pc_write:   PCWriteD
  };

  cond_eval u_cond_eval (
    .cond  (ex_q.cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign CondExE      = ex_q.valid & cond_pass;
  assign BranchTakenE = CondExE & ex_q.branch;
  assign CarryInE     = flags_q[FLAG_C];
  assign FlagsQ       = flags_q;

  // Execute never sees an upstream stall bubble: a stalled Decode means Stall[0], which holds.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking <= so every flop samples the pre-edge values.
    if (reset) begin
      ex_q      <= '0;
      ex_ctrl_q <= '0;
    end else if (Flush[0]) begin
      ex_q      <= '0;
      ex_ctrl_q <= '0;
    end else if (!Stall[0]) begin
      ex_q      <= dec;
      ex_ctrl_q <= CtrlD;
    end
  end

  // Flags commit when the instruction leaves Execute; a flush of the slot behind it does not block that.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (CondExE && !Stall[0]) begin
      if (ex_q.flag_write[1]) flags_q[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
      if (ex_q.flag_write[0]) flags_q[FLAG_C:FLAG_V] <= ALUFlagsE[FLAG_C:FLAG_V];
    end
  end

  always_comb begin
    src_valid = '0;
    src_rw    = '0;
    src_mw    = '0;
    src_pw    = '0;
    for (int k = 1; k < NSTAGES; k++) src_ctrl[k] = '0;

    src_valid[1] = ex_q.valid;
    src_rw[1]    = ex_q.reg_write & CondExE;
    src_mw[1]    = ex_q.mem_write & CondExE;
    src_pw[1]    = ex_q.pc_write  & CondExE;
    src_ctrl[1]  = ex_ctrl_q;

    for (int k = 2; k < NSTAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_rw[k]    = rw_q[k-1];
      src_mw[k]    = mw_q[k-1];
      src_pw[k]    = pw_q[k-1];
      src_ctrl[k]  = ctrl_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: ctrl_q is a few flops per stage, not a RAM, so it resets with the rest of the stage.
    if (reset) begin
      valid_q <= '0;
      rw_q    <= '0;
      mw_q    <= '0;
      pw_q    <= '0;
      for (int k = 1; k < NSTAGES; k++) ctrl_q[k] <= '0;
    end else begin
      for (int k = 1; k < NSTAGES; k++) begin
        if (Flush[k] || (!Stall[k] && Stall[k-1])) begin
          valid_q[k] <= 1'b0;
          rw_q[k]    <= 1'b0;
          mw_q[k]    <= 1'b0;
          pw_q[k]    <= 1'b0;
          ctrl_q[k]  <= '0;
        end else if (!Stall[k]) begin
          valid_q[k] <= src_valid[k];
          rw_q[k]    <= src_rw[k];
          mw_q[k]    <= src_mw[k];
          pw_q[k]    <= src_pw[k];
          ctrl_q[k]  <= src_ctrl[k];
        end
      end
    end
  end

  assign ValidS    = {valid_q, ex_q.valid};
  assign RegWriteS = {rw_q & valid_q, ex_q.reg_write & CondExE};
  assign MemWriteS = {mw_q & valid_q, ex_q.mem_write & CondExE};
  assign PCWriteS  = {pw_q & valid_q, ex_q.pc_write  & CondExE};

  assign CtrlS[0 +: CTRLW] = ex_ctrl_q;
  for (genvar g = 1; g < NSTAGES; g++) begin : g_ctrl_out
    assign CtrlS[g*CTRLW +: CTRLW] = ctrl_q[g];
  end

  // Execute term ignores the condition so fetch stays conservative until it resolves.
  assign PCWrPendingF = (ValidD & PCWriteD)
                      | (ex_q.valid & ex_q.pc_write)
                      | (|(valid_q & pw_q));

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomised and directed bench for ctrl_pipe against an array-based
// reference model of the control pipeline and ARM condition rules.
module tb_ctrl_pipe;

  localparam int NS = 3;
  localparam int CW = 4;
  localparam int BNS = 5;
  localparam int BCW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic          reset;
  logic          ValidD, BranchD, RegWriteD, MemWriteD, PCWriteD;
  logic [3:0]    CondD, ALUFlagsE;
  logic [1:0]    FlagWriteD;
  logic [CW-1:0] CtrlD;
  logic [NS-1:0] Stall, Flush;
  logic          CondExE, BranchTakenE, CarryInE, PCWrPendingF;
  logic [3:0]    FlagsQ;
  logic [NS-1:0] ValidS, RegWriteS, MemWriteS, PCWriteS;
  logic [NS*CW-1:0] CtrlS;

  ctrl_pipe #(.NSTAGES(NS), .CTRLW(CW)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .CondD(CondD), .FlagWriteD(FlagWriteD),
    .BranchD(BranchD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .PCWriteD(PCWriteD),
    .CtrlD(CtrlD), .ALUFlagsE(ALUFlagsE), .Stall(Stall), .Flush(Flush),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .CarryInE(CarryInE), .FlagsQ(FlagsQ),
    .ValidS(ValidS), .RegWriteS(RegWriteS), .MemWriteS(MemWriteS), .PCWriteS(PCWriteS),
    .CtrlS(CtrlS), .PCWrPendingF(PCWrPendingF)
  );

  // Second instance: deeper, wider pipe
  logic           b_reset, b_valid, b_branch, b_rw, b_mw, b_pw;
  logic [3:0]     b_cond, b_alu;
  logic [1:0]     b_fw;
  logic [BCW-1:0] b_ctrl;
  logic [BNS-1:0] b_stall, b_flush;
  logic           b_condex, b_btaken, b_carry, b_pend;
  logic [3:0]     b_flags;
  logic [BNS-1:0] b_valids, b_rws, b_mws, b_pws;
  logic [BNS*BCW-1:0] b_ctrls;

  ctrl_pipe #(.NSTAGES(BNS), .CTRLW(BCW)) dut_b (
    .clk(clk), .reset(b_reset), .ValidD(b_valid), .CondD(b_cond), .FlagWriteD(b_fw),
    .BranchD(b_branch), .RegWriteD(b_rw), .MemWriteD(b_mw), .PCWriteD(b_pw),
    .CtrlD(b_ctrl), .ALUFlagsE(b_alu), .Stall(b_stall), .Flush(b_flush),
    .CondExE(b_condex), .BranchTakenE(b_btaken), .CarryInE(b_carry), .FlagsQ(b_flags),
    .ValidS(b_valids), .RegWriteS(b_rws), .MemWriteS(b_mws), .PCWriteS(b_pws),
    .CtrlS(b_ctrls), .PCWrPendingF(b_pend)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // A stage may only stall if every stage upstream of it stalls too.
  always @(negedge clk) begin
    for (int k = 1; k < NS; k++)
      if (!reset && Stall[k]) assert (Stall[k-1]) else $error("stall contract broken: %b", Stall);
  end

  // ---------------- reference model ----------------
  bit          mv [NS];
  bit          mrw[NS];
  bit          mmw[NS];
  bit          mpw[NS];
  bit [CW-1:0] mctrl[NS];
  bit [3:0]    mcond;
  bit [1:0]    mfw;
  bit          mbr;
  bit [3:0]    mflags;

  // ARM encoding: code[3:1] picks the base test, code[0] inverts it.
  function automatic bit cond_ok(input bit [3:0] code, input bit [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (code == 4'hF) return 1'b0;
    if (code == 4'hE) return 1'b1;
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return code[0] ? !base : base;
  endfunction

  task automatic compare_all();
    bit cx, pend;
    logic [NS-1:0]    ev, erw, emw, epw;
    logic [NS*CW-1:0] ectrl;
    cx = mv[0] && cond_ok(mcond, mflags);
    pend = ValidD && PCWriteD;
    for (int k = 0; k < NS; k++) begin
      ev[k]  = mv[k];
      erw[k] = (k == 0) ? (mrw[0] && cx) : (mrw[k] && mv[k]);
      emw[k] = (k == 0) ? (mmw[0] && cx) : (mmw[k] && mv[k]);
      epw[k] = (k == 0) ? (mpw[0] && cx) : (mpw[k] && mv[k]);
      ectrl[k*CW +: CW] = mctrl[k];
      pend = pend || (mv[k] && mpw[k]);
    end
    check("CondExE", CondExE, cx);
    check("BranchTakenE", BranchTakenE, cx && mbr);
    check("CarryInE", CarryInE, mflags[1]);
    check("FlagsQ", FlagsQ, mflags);
    check("ValidS", ValidS, ev);
    check("RegWriteS", RegWriteS, erw);
    check("MemWriteS", MemWriteS, emw);
    check("PCWriteS", PCWriteS, epw);
    check("CtrlS", CtrlS, ectrl);
    check("PCWrPendingF", PCWrPendingF, pend);
  endtask

  task automatic model_step();
    bit cx;
    bit          nv[NS], nrw[NS], nmw[NS], npw[NS];
    bit [CW-1:0] nctrl[NS];
    bit          sv, srw, smw, spw;
    bit [CW-1:0] sctrl;
    if (reset) begin
      for (int k = 0; k < NS; k++) begin
        mv[k] = 0; mrw[k] = 0; mmw[k] = 0; mpw[k] = 0; mctrl[k] = '0;
      end
      mcond = '0; mfw = '0; mbr = 0; mflags = '0;
      return;
    end
    cx = mv[0] && cond_ok(mcond, mflags);
    for (int k = 0; k < NS; k++) begin
      nv[k] = mv[k]; nrw[k] = mrw[k]; nmw[k] = mmw[k]; npw[k] = mpw[k]; nctrl[k] = mctrl[k];
      if (k == 0) begin
        sv = ValidD; srw = RegWriteD; smw = MemWriteD; spw = PCWriteD; sctrl = CtrlD;
      end else begin
        sv = mv[k-1]; sctrl = mctrl[k-1];
        srw = mrw[k-1] && (k > 1 || cx);
        smw = mmw[k-1] && (k > 1 || cx);
        spw = mpw[k-1] && (k > 1 || cx);
      end
      if (Flush[k] || (!Stall[k] && k > 0 && Stall[k-1])) begin
        nv[k] = 0; nrw[k] = 0; nmw[k] = 0; npw[k] = 0; nctrl[k] = '0;
      end else if (!Stall[k]) begin
        nv[k] = sv; nrw[k] = srw; nmw[k] = smw; npw[k] = spw; nctrl[k] = sctrl;
      end
    end
    if (cx && !Stall[0]) begin
      if (mfw[1]) mflags[3:2] = ALUFlagsE[3:2];
      if (mfw[0]) mflags[1:0] = ALUFlagsE[1:0];
    end
    if (Flush[0]) begin
      mcond = '0; mfw = '0; mbr = 0;
    end else if (!Stall[0]) begin
      mcond = CondD; mfw = FlagWriteD; mbr = BranchD;
    end
    for (int k = 0; k < NS; k++) begin
      mv[k] = nv[k]; mrw[k] = nrw[k]; mmw[k] = nmw[k]; mpw[k] = npw[k]; mctrl[k] = nctrl[k];
    end
  endtask

  // Check outputs mid-cycle, then advance model with the DUT edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic dec(input bit v, input bit [3:0] cond, input bit [1:0] fw, input bit br,
                     input bit rw, input bit mw, input bit pw, input bit [CW-1:0] ctrl);
    ValidD = v; CondD = cond; FlagWriteD = fw; BranchD = br;
    RegWriteD = rw; MemWriteD = mw; PCWriteD = pw; CtrlD = ctrl;
  endtask

  task automatic randomize_inputs();
    int depth;
    ValidD     = ($urandom_range(3) != 0);
    CondD      = ($urandom_range(2) == 0) ? 4'hE : 4'($urandom_range(15));
    FlagWriteD = 2'($urandom_range(3));
    BranchD    = ($urandom_range(3) == 0);
    RegWriteD  = $urandom_range(1) == 1;
    MemWriteD  = $urandom_range(1) == 1;
    PCWriteD   = ($urandom_range(4) == 0);
    CtrlD      = CW'($urandom);
    ALUFlagsE  = 4'($urandom_range(15));
    depth      = ($urandom_range(4) == 0) ? $urandom_range(1, NS) : 0;
    Stall      = NS'((1 << depth) - 1);
    Flush      = ($urandom_range(6) == 0) ? NS'($urandom) : '0;
    reset      = ($urandom_range(63) == 0);
  endtask

  initial begin
    reset = 1'b1; Stall = '0; Flush = '0; ALUFlagsE = '0;
    dec(0, 4'h0, 2'b00, 0, 0, 0, 0, '0);
    b_reset = 1'b1; b_valid = 0; b_branch = 0; b_rw = 0; b_mw = 0; b_pw = 0;
    b_cond = '0; b_alu = '0; b_fw = '0; b_ctrl = '0; b_stall = '0; b_flush = '0;

    @(posedge clk); model_step(); #1;
    cycle();                                  // reset state: all zero
    reset = 1'b0;

    // ADDS, AL, sets NZCV = 0110
    dec(1, 4'hE, 2'b11, 0, 1, 0, 0, 4'h3); ALUFlagsE = 4'b0110;
    cycle();
    dec(0, 4'h0, 2'b00, 0, 0, 0, 0, '0);
    cycle();
    check("adds_flags", FlagsQ, 4'b0110);
    cycle();
    check("adds_rw2", RegWriteS[2], 1'b1);

    // BEQ then BNE with Z = 1
    dec(1, 4'h0, 2'b00, 1, 0, 0, 0, '0);
    cycle();
    check("beq_taken", BranchTakenE, 1'b1);
    dec(1, 4'h1, 2'b00, 1, 0, 0, 0, '0);
    cycle();
    check("bne_taken", BranchTakenE, 1'b0);

    // STR NE while Z = 1, then NV condition
    dec(1, 4'h1, 2'b00, 0, 0, 1, 0, '0);
    cycle();
    dec(1, 4'hF, 2'b11, 0, 1, 1, 0, '0);
    cycle();
    check("str_ne_mw1", MemWriteS[1], 1'b0);
    check("str_ne_v1", ValidS[1], 1'b1);
    check("nv_condex", CondExE, 1'b0);

    // Flag-setter held in Execute for two cycles
    dec(1, 4'hE, 2'b11, 0, 0, 0, 0, '0); ALUFlagsE = 4'b1001;
    cycle();
    dec(0, 4'h0, 2'b00, 0, 0, 0, 0, '0); Stall = 3'b001;
    cycle();
    check("stall_flags_a", FlagsQ, 4'b0110);
    check("stall_v1_a", ValidS[1], 1'b0);
    cycle();
    check("stall_flags_b", FlagsQ, 4'b0110);
    check("stall_v1_b", ValidS[1], 1'b0);
    Stall = '0;
    cycle();
    check("release_flags", FlagsQ, 4'b1001);
    ALUFlagsE = 4'b0000;
    cycle();
    check("flags_once", FlagsQ, 4'b1001);

    // Flush + Stall on Execute: bubble, no flag update
    dec(1, 4'hE, 2'b11, 0, 1, 0, 0, '0); ALUFlagsE = 4'b0011;
    cycle();
    dec(0, 4'h0, 2'b00, 0, 0, 0, 0, '0); Stall = 3'b001; Flush = 3'b001;
    cycle();
    check("flush_stall_flags", FlagsQ, 4'b1001);
    check("flush_stall_v0", ValidS[0], 1'b0);
    Stall = '0; Flush = '0;
    cycle();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      cycle();
    end
    reset = 1'b1; Stall = '0; Flush = '0;
    dec(0, 4'h0, 2'b00, 0, 0, 0, 0, '0);
    cycle();

    // Deep pipe: PC write with Ctrl = A5 travels 5 stages
    b_reset = 1'b0;
    b_valid = 1; b_pw = 1; b_rw = 1; b_cond = 4'hE; b_ctrl = 8'hA5;
    #1;
    check("b_pend_decode", b_pend, 1'b1);
    @(posedge clk); #1;
    b_valid = 0; b_pw = 0; b_rw = 0; b_ctrl = '0;
    for (int i = 0; i < BNS; i++) begin
      check("b_pend_stage", b_pend, 1'b1);
      if (i == BNS - 1) begin
        check("b_ctrl_s4", b_ctrls[4*BCW +: BCW], 8'hA5);
        check("b_rw_s4", b_rws[4], 1'b1);
      end
      @(posedge clk); #1;
    end
    check("b_pend_clear", b_pend, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised control-signal pipeline for the pipelined LEG core; successor to the fixed E/M/W control registers.
- Accepts a decoded control bundle from Decode and carries it through NSTAGES post-decode stages. Stage 0 is Execute; the last stage is Writeback.
- Evaluates the ARM condition field in Execute and gates the write enables, which stay gated downstream.
- Owns the NZCV flags register. Adds per-stage stall/flush and a valid bit per stage.

Parameters:
- NSTAGES, 3, number of post-decode stages (min 2); index 0 = Execute, NSTAGES-1 = Writeback.
- CTRLW, 4, width of the opaque pass-through control field (e.g. ALUSrc, MemtoReg, swap).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ValidD  in  1  Decode holds a real instruction
- CondD  in  4  condition field (Instr[31:28])
- FlagWriteD  in  2  [1] = update NZ, [0] = update CV
- BranchD  in  1  branch instruction
- RegWriteD  in  1  register write
- MemWriteD  in  1  memory write
- PCWriteD  in  1  writes PC (Rd = 15 with RegWrite)
- CtrlD  in  CTRLW  pass-through control
- ALUFlagsE  in  4  NZCV from the Execute ALU
- Stall  in  NSTAGES  per-stage hold
- Flush  in  NSTAGES  per-stage bubble insert
- CondExE  out  1  Execute instruction passes its condition
- BranchTakenE  out  1  valid & Branch & CondEx in Execute
- CarryInE  out  1  registered C flag
- FlagsQ  out  4  architectural NZCV
- ValidS  out  NSTAGES  valid per stage
- RegWriteS  out  NSTAGES  gated RegWrite per stage
- MemWriteS  out  NSTAGES  gated MemWrite per stage
- PCWriteS  out  NSTAGES  gated PCWrite per stage
- CtrlS  out  NSTAGES*CTRLW  Ctrl per stage, stage k at bits [k*CTRLW +: CTRLW]
- PCWrPendingF  out  1  a PC write is in flight

Behaviour:
- Reset: all stage registers clear to 0 (valid = 0, enables = 0, Ctrl = 0) and FlagsQ = 0. All outputs are 0 the cycle after reset. Reset mid-operation discards every in-flight instruction.
- Stage record: valid, Cond, FlagWrite, Branch, RegWrite, MemWrite, PCWrite, Ctrl. Stages 1 and up hold only valid, RegWrite, MemWrite, PCWrite and Ctrl, stored already gated.
- Advance at each edge, stage k (source = Decode for k = 0, else stage k-1):
  - Flush[k] = 1: stage k loads a bubble (all fields 0). Flush has priority over Stall.
  - Else Stall[k] = 1: stage k holds its contents.
  - Else, if the source is stalled (Stall[k-1], or for k = 0 an external stall of Decode implied by Stall[0]): stage k loads a bubble.
  - Else: stage k loads the source.
- Stall contract: if Stall[k] = 1 then Stall[j] = 1 for all j < k. The bench asserts this; the RTL does not repair it.
- Condition evaluation (combinational, from FlagsQ and the stage-0 Cond):
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE as ARM; AL = 1.
  - Code 4'b1111 gives 0 (defined; never X).
  - CondExE = valid0 & condpass.
- Gating into stage 1: RegWrite, MemWrite and PCWrite are each ANDed with CondExE. Outputs for stage 0 (RegWriteS[0] etc.) are also gated by CondExE. Stages 1 and up output their stored values ANDed with their valid bit.
- Flags update at the edge when valid0 & CondExE & ~Stall[0]:
  - FlagWrite[1]: NZ <= ALUFlagsE[3:2].
  - FlagWrite[0]: CV <= ALUFlagsE[1:0].
  - A stalled Execute instruction updates flags exactly once, on the cycle it leaves. Flush[0] does not block the update of the instruction currently in Execute.
- Back-to-back flag producer/consumer: the consumer reaches Execute one cycle later and sees the updated FlagsQ; no forwarding is needed.
- CarryInE = FlagsQ[1].
- PCWrPendingF = (ValidD & PCWriteD) | OR over k of (valid_k & PCWrite_k), with the stage-0 term ungated by the condition (conservative).
- Latency: Decode to stage k output is k+1 cycles when no stalls occur.

Decomposition:
- Package leg_ctrl_pkg:
  - cond_e enum (EQ..AL, NV).
  - Flag bit indices: N = 3, Z = 2, C = 1, V = 0.
  - Packed struct stage_ctrl_t for the stage record.
- One combinational sub-module cond_eval (cond, flags -> pass), reusable by other cores.

Test Plan:
- Reset, then ADDS with AL, FlagWrite = 11, ALUFlagsE = 4'b0110 -> FlagsQ = 0110 one edge later; RegWriteS[2] = 1 after 3 cycles.
- Flags = Z = 1; BEQ then BNE in consecutive cycles -> BranchTakenE = 1 then 0; neither reaches MemWriteS/RegWriteS.
- STR with Cond = NE while Z = 1 -> MemWriteS[1] = 0 and ValidS[1] = 1; Cond = 4'b1111 -> CondExE = 0, never X.
- Stall[0] held 2 cycles with a flag-setting instruction in Execute -> FlagsQ changes once, after release; ValidS[1] = 0 during the stall.
- Flush[0] and Stall[0] together -> stage 0 becomes a bubble, and the outgoing instruction's flag update occurs only if Stall[0] = 0.
- PC write (RegWrite, Rd = 15) entering Decode -> PCWrPendingF = 1 from Decode through stage NSTAGES-1, then 0. Repeat with NSTAGES = 5, CTRLW = 8, Ctrl = 8'hA5 -> CtrlS slice 4 = A5 after 5 cycles.
